// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target memory block.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR_RX,
        ST_DATA_RX,
        ST_RX_ACK,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_WAIT_STOP
    } i2c_tgt_state_t;

    localparam logic I2C_ACK         = 1'b0;
    localparam logic I2C_NACK        = 1'b1;
    localparam int   I2C_SYNC_STAGES = 2;

endpackage

// File: rtl/i2c_target_mem_if.sv
// Pad-side and write-notification signals of the I2C target memory.
interface i2c_target_mem_if #(
    parameter int MEM_DEPTH = 128
);
    localparam int PW = $clog2(MEM_DEPTH);

    logic          scl_i;
    logic          sda_i;
    logic          sda_oe;
    logic          busy;
    logic          wr_valid;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;

    modport slave (
        input  scl_i, sda_i,
        output sda_oe, busy, wr_valid, wr_addr, wr_data
    );

    modport master (
        output scl_i, sda_i,
        input  sda_oe, busy, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizer + edge detector for one I2C line.
// Optional 3-sample stable filter when I2C_TGT_GLITCH_FILTER_EN is defined.
module i2c_line_sync
    import i2c_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic pad,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic [I2C_SYNC_STAGES-1:0] sync;
    logic cur;
    logic prv;

    // Idle bus level is high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk) begin
        if (rst) sync <= '1;
        else     sync <= {sync[I2C_SYNC_STAGES-2:0], pad};
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic [2:0] win;

    assign win = {hist, sync[I2C_SYNC_STAGES-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '1;
            cur  <= 1'b1;
        end else begin
            hist <= {hist[0], sync[I2C_SYNC_STAGES-1]};
            if (&win)       cur <= 1'b1;
            else if (~|win) cur <= 1'b0;
        end
    end
`else
    assign cur = sync[I2C_SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) prv <= 1'b1;
        else     prv <= cur;
    end

    assign lvl  = cur;
    assign rise = cur & ~prv;
    assign fall = ~cur & prv;
endmodule

// File: rtl/i2c_target_mem.sv
// I2C target with pointer-addressed, auto-incrementing register memory.
// Optional input glitch filter: I2C_TGT_GLITCH_FILTER_EN (see i2c_line_sync).
//
// state        | meaning
// ST_IDLE      | waiting for START
// ST_ADDR      | shifting in address + R/W
// ST_ADDR_ACK  | ACK address (first fall drives, second fall moves on)
// ST_PTR_RX    | shifting in memory pointer
// ST_DATA_RX   | shifting in write data
// ST_RX_ACK    | ACK received byte
// ST_TX_BYTE   | driving read data on SCL falls
// ST_TX_ACK    | sampling controller ACK/NACK
// ST_WAIT_STOP | not addressed, ignoring bus
module i2c_target_mem
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         MEM_DEPTH = 128
)(
    input  logic             clk,
    input  logic             rst,
    i2c_target_mem_if.slave  bus
);
    localparam int PW = $clog2(MEM_DEPTH);

    i2c_tgt_state_t state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic [6:0]    shift, shift_nxt;
    logic [PW-1:0] ptr, ptr_nxt;
    logic          oe, oe_nxt;
    logic          busy, busy_nxt;
    logic          ack_on, ack_on_nxt;
    logic          rw, rw_nxt;
    logic          we;
    logic [7:0]    rx_byte;
    logic [7:0]    rd_data;
    logic [7:0]    mem [MEM_DEPTH];
    logic          wr_valid;
    logic [PW-1:0] wr_addr;
    logic [7:0]    wr_data;

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start, stop;

    i2c_line_sync u_scl (.clk(clk), .rst(rst), .pad(bus.scl_i),
                         .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_line_sync u_sda (.clk(clk), .rst(rst), .pad(bus.sda_i),
                         .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    // An SCL edge in the same sample masks any SDA change (no START/STOP).
    assign start   = sda_fall & scl_lvl & ~scl_rise & ~scl_fall;
    assign stop    = sda_rise & scl_lvl & ~scl_rise & ~scl_fall;
    assign rx_byte = {shift, sda_lvl};

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shift_nxt  = shift;
        ptr_nxt    = ptr;
        oe_nxt     = oe;
        busy_nxt   = busy;
        ack_on_nxt = ack_on;
        rw_nxt     = rw;
        we         = 1'b0;
        if (stop) begin
            state_nxt = ST_IDLE;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
        end else if (start) begin
            state_nxt  = ST_ADDR;
            cnt_nxt    = '0;
            oe_nxt     = 1'b0;
            busy_nxt   = 1'b1;
            ack_on_nxt = 1'b0;
        end else begin
            unique case (state)
                ST_ADDR: if (scl_rise) begin
                    shift_nxt = rx_byte[6:0];
                    cnt_nxt   = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_nxt    = '0;
                        rw_nxt     = rx_byte[0];
                        ack_on_nxt = 1'b0;
                        state_nxt  = (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                    end
                end
                ST_ADDR_ACK: if (scl_fall) begin
                    if (!ack_on) begin
                        oe_nxt     = 1'b1;
                        ack_on_nxt = 1'b1;
                    end else if (rw) begin
                        ack_on_nxt = 1'b0;
                        shift_nxt  = rd_data[6:0];
                        oe_nxt     = ~rd_data[7];
                        cnt_nxt    = 4'd1;
                        state_nxt  = ST_TX_BYTE;
                    end else begin
                        ack_on_nxt = 1'b0;
                        oe_nxt     = 1'b0;
                        cnt_nxt    = '0;
                        state_nxt  = ST_PTR_RX;
                    end
                end
                ST_PTR_RX, ST_DATA_RX: if (scl_rise) begin
                    shift_nxt = rx_byte[6:0];
                    cnt_nxt   = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_nxt   = '0;
                        state_nxt = ST_RX_ACK;
                        if (state == ST_PTR_RX) begin
                            ptr_nxt = rx_byte[PW-1:0];
                        end else begin
                            we      = 1'b1;
                            ptr_nxt = ptr + PW'(1);
                        end
                    end
                end
                ST_RX_ACK: if (scl_fall) begin
                    if (!ack_on) begin
                        oe_nxt     = 1'b1;
                        ack_on_nxt = 1'b1;
                    end else begin
                        ack_on_nxt = 1'b0;
                        oe_nxt     = 1'b0;
                        cnt_nxt    = '0;
                        state_nxt  = ST_DATA_RX;
                    end
                end
                ST_TX_BYTE: if (scl_fall) begin
                    if (cnt == 4'd8) begin
                        oe_nxt    = 1'b0;
                        state_nxt = ST_TX_ACK;
                    end else if (cnt == 4'd0) begin
                        shift_nxt = rd_data[6:0];
                        oe_nxt    = ~rd_data[7];
                        cnt_nxt   = 4'd1;
                    end else begin
                        oe_nxt    = ~shift[6];
                        shift_nxt = {shift[5:0], 1'b0};
                        cnt_nxt   = cnt + 4'd1;
                    end
                end
                ST_TX_ACK: if (scl_rise) begin
                    ptr_nxt   = ptr + PW'(1);
                    cnt_nxt   = '0;
                    state_nxt = (sda_lvl == I2C_ACK) ? ST_TX_BYTE : ST_WAIT_STOP;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            shift    <= '0;
            ptr      <= '0;
            oe       <= 1'b0;
            busy     <= 1'b0;
            ack_on   <= 1'b0;
            rw       <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_data  <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            cnt      <= cnt_nxt;
            shift    <= shift_nxt;
            ptr      <= ptr_nxt;
            oe       <= oe_nxt;
            busy     <= busy_nxt;
            ack_on   <= ack_on_nxt;
            rw       <= rw_nxt;
            wr_valid <= we;
            rd_data  <= mem[ptr];
            if (we) begin
                mem[ptr] <= rx_byte;
                wr_addr  <= ptr;
                wr_data  <= rx_byte;
            end
        end
    end

    assign bus.sda_oe   = oe;
    assign bus.busy     = busy;
    assign bus.wr_valid = wr_valid;
    assign bus.wr_addr  = wr_addr;
    assign bus.wr_data  = wr_data;
endmodule

// File: tb/tb_i2c_target_mem.sv
// Scoreboard bench for i2c_target_mem: bit-banged I2C controller plus a byte-level memory model.
module tb_i2c_target_mem;
    import i2c_pkg::*;

    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ctrl_sda = 1'b1;
    always #5 clk = ~clk;

    i2c_target_mem_if #(.MEM_DEPTH(128)) bus ();
    assign bus.sda_i = ctrl_sda & ~bus.sda_oe;

    i2c_target_mem #(.DEV_ADDR(7'h50), .MEM_DEPTH(128)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct { logic [6:0] a; logic [7:0] d; } wr_t;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] mem_m [128];
    int         ptr_m = 0;
    wr_t        wr_q [$];
    int         rsp_exp [$];
    int         rsp_obs [$];
    string      rsp_name [$];
    bit         watch_oe = 0;
    bit         oe_seen = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // write-port monitor
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.wr_valid) begin
            if (wr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_unexpected: addr 0x%0h data 0x%0h, expected no write", bus.wr_addr, bus.wr_data);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", int'(bus.wr_addr), int'(e.a));
                check("wr_data", int'(bus.wr_data), int'(e.d));
            end
        end
    end

    // bus-response checker (ACK bits and read bytes)
    always @(negedge clk) begin
        while (rsp_obs.size() > 0 && rsp_exp.size() > 0)
            check(rsp_name.pop_front(), rsp_obs.pop_front(), rsp_exp.pop_front());
    end

    always @(negedge clk) if (watch_oe && bus.sda_oe) oe_seen = 1;

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog: got no end of test, expected finish within 150000 cycles");
        $fatal(1, "timeout");
    end

    task automatic wq(input int n = Q);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_c();
        ctrl_sda = 1'b1; wq();
        bus.scl_i = 1'b1; wq();
        ctrl_sda = 1'b0; wq();
        bus.scl_i = 1'b0; wq();
    endtask

    task automatic stop_c();
        ctrl_sda = 1'b0; wq();
        bus.scl_i = 1'b1; wq();
        ctrl_sda = 1'b1; wq();
    endtask

    task automatic wbit(input logic b, input bit glitch);
        ctrl_sda = b; wq();
        bus.scl_i = 1'b1;
        if (glitch) begin
            wq(4); bus.scl_i = 1'b0; wq(2); bus.scl_i = 1'b1; wq(10);
        end else begin
            wq(2 * Q);
        end
        bus.scl_i = 1'b0; wq();
    endtask

    task automatic rbit(output logic b);
        ctrl_sda = 1'b1; wq();
        bus.scl_i = 1'b1; wq();
        b = bus.sda_i; wq();
        bus.scl_i = 1'b0; wq();
    endtask

    task automatic wbyte(input logic [7:0] v, input int exp_ack, input string nm);
        logic a;
        for (int i = 7; i >= 0; i--) wbit(v[i], 1'b0);
        rbit(a);
        rsp_name.push_back(nm);
        rsp_exp.push_back(exp_ack);
        rsp_obs.push_back(int'(a));
    endtask

    task automatic rbyte(input logic ack, output logic [7:0] v);
        for (int i = 7; i >= 0; i--) rbit(v[i]);
        wbit(ack, 1'b0);
    endtask

    task automatic model_write(input logic [7:0] d);
        wr_t e;
        e.a = 7'(ptr_m);
        e.d = d;
        mem_m[ptr_m] = d;
        wr_q.push_back(e);
        ptr_m = (ptr_m + 1) % 128;
    endtask

    task automatic do_write(input int p, input logic [7:0] d [$]);
        start_c();
        check("busy_after_start", int'(bus.busy), 1);
        wbyte(8'hA0, 0, "ack_addr_w");
        wbyte(8'(p), 0, "ack_ptr");
        ptr_m = p % 128;
        foreach (d[i]) begin
            model_write(d[i]);
            wbyte(d[i], 0, "ack_data");
        end
        stop_c();
        wq(4);
        check("busy_after_stop", int'(bus.busy), 0);
    endtask

    task automatic do_read(input int p, input bit set_ptr, input int n);
        logic [7:0] v;
        start_c();
        if (set_ptr) begin
            wbyte(8'hA0, 0, "ack_addr_w");
            wbyte(8'(p), 0, "ack_ptr");
            ptr_m = p % 128;
            start_c();
        end
        wbyte(8'hA1, 0, "ack_addr_r");
        for (int i = 0; i < n; i++) begin
            rsp_name.push_back("read_byte");
            rsp_exp.push_back(int'(mem_m[ptr_m]));
            rbyte((i == n - 1) ? I2C_NACK : I2C_ACK, v);
            rsp_obs.push_back(int'(v));
            ptr_m = (ptr_m + 1) % 128;
        end
        stop_c();
        wq(4);
        check("ptr_after_read", int'(dut.ptr), ptr_m);
        check("sda_released", int'(bus.sda_oe), 0);
    endtask

    initial begin
        logic [7:0] d [$];
        logic [7:0] g, gexp;
        logic [6:0] bad;

        for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
        bus.scl_i = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        wq(4);
        check("rst_sda_oe", int'(bus.sda_oe), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_wr_valid", int'(bus.wr_valid), 0);
        check("rst_wr_addr", int'(bus.wr_addr), 0);
        check("rst_wr_data", int'(bus.wr_data), 0);

        d = '{8'h11, 8'h22};
        do_write(8'h10, d);
        do_read(8'h10, 1'b1, 2);

        // address mismatch: never drive SDA, never write
        for (int k = 0; k < 3; k++) begin
            if (k == 0) bad = 7'h58;
            else begin
                bad = 7'($urandom_range(0, 127));
                if (bad == 7'h50) bad = 7'h51;
            end
            oe_seen = 0;
            start_c();
            watch_oe = 1;
            wbyte({bad, 1'($urandom_range(0, 1))}, 1, "nack_addr");
            wbyte(8'($urandom), 1, "nack_byte");
            stop_c();
            watch_oe = 0;
            check("oe_during_mismatch", int'(oe_seen), 0);
        end

        d = '{8'hAA, 8'hBB};
        do_write(8'h7F, d);
        do_read(8'h7F, 1'b1, 2);
        do_read(0, 1'b0, 2);

        for (int it = 0; it < 6; it++) begin
            d.delete();
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) d.push_back(8'($urandom));
            do_write(int'($urandom_range(0, 255)), d);
            do_read(int'($urandom_range(0, 255)), 1'b1, int'($urandom_range(1, 3)));
        end

        // SCL glitch during the MSB of a data byte
        g = 8'($urandom);
`ifdef I2C_TGT_GLITCH_FILTER_EN
        gexp = g;
`else
        gexp = {g[7], g[7], g[6:1]};
`endif
        start_c();
        wbyte(8'hA0, 0, "ack_addr_w");
        wbyte(8'h40, 0, "ack_ptr");
        ptr_m = 8'h40;
        model_write(gexp);
        wbit(g[7], 1'b1);
        for (int i = 6; i >= 0; i--) wbit(g[i], 1'b0);
        stop_c();
        wq(4);
        do_read(8'h40, 1'b1, 1);

        // reset in the middle of a data byte
        start_c();
        wbyte(8'hA0, 0, "ack_addr_w");
        wbyte(8'h20, 0, "ack_ptr");
        wbit(1'b0, 1'b0); wbit(1'b1, 1'b0); wbit(1'b0, 1'b0);
        ctrl_sda = 1'b1; wq();
        bus.scl_i = 1'b1; wq();
        rst = 1'b1;
        @(negedge clk);
        check("abort_sda_oe", int'(bus.sda_oe), 0);
        check("abort_busy", int'(bus.busy), 0);
        wq(2);
        rst = 1'b0;
        for (int i = 0; i < 128; i++) mem_m[i] = 8'h00;
        ptr_m = 0;
        wq();
        bus.scl_i = 1'b0; wq();
        stop_c();
        wq(4);
        do_read(8'h10, 1'b1, 2);
        do_read(8'h7F, 1'b1, 2);
        d = '{8'h5C, 8'hC3, 8'h01};
        do_write(8'h05, d);
        do_read(8'h05, 1'b1, 3);

        wq(20);
        check("wr_queue_drained", wr_q.size(), 0);
        check("rsp_queue_drained", rsp_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_target_mem.md
# i2c_target_mem

Standalone I2C target (responder) with an internal 8-bit register memory, attached to real open-drain SCL/SDA lines that an external controller drives. It decodes START, STOP and repeated START. It matches a 7-bit device address, accepts a one-byte memory pointer, then performs auto-incrementing burst writes or reads. It is the device-side counterpart to the team's I2C controller blocks and sits behind the pad ring, oversampling the bus with the system clock.

## Interface
- `DEV_ADDR`, 7'h50: 7-bit device address this target acknowledges.
- `MEM_DEPTH`, 128: memory bytes, power of two, 2..128; pointer width `PW = $clog2(MEM_DEPTH)`.
- `clk` input, 1: system clock, at least 16x SCL frequency.
- `rst` input, 1: reset, synchronous, active-high; clock `clk`.
- `scl_i` input, 1: raw SCL pad input (asynchronous).
- `sda_i` input, 1: raw SDA pad input (asynchronous).
- `sda_oe` output, 1: 1 = pull SDA low, 0 = release; the pad is open-drain.
- `busy` output, 1: high from a detected START to the next STOP.
- `wr_valid` output, 1: one-cycle pulse when a byte is written to memory.
- `wr_addr` output, PW: memory index of that write.
- `wr_data` output, 8: data of that write.

## Operation
- **Line conditioning.** `scl_i` and `sda_i` each pass through a 2-FF synchronizer. Edge detection compares the current synchronized sample `s` with the previous sample `p`.
- **START.** SDA falls (`p`=1, `s`=0) while SCL is high in both samples. It is valid in any state, including mid-byte (repeated START). It releases `sda_oe`, clears the bit counter, sets `busy`, and goes to ADDR.
- **STOP.** SDA rises while SCL is high in both samples. It releases `sda_oe`, clears `busy`, and goes to IDLE. It takes priority over every state.
- **Data bits.** Bits are sampled on a detected SCL rise, MSB first. `sda_oe` changes only on a detected SCL fall.
- **FSM states** (enum `i2c_tgt_state_t`):
  - **IDLE**: waits for START.
  - **ADDR**: shifts in 8 bits. On the 8th SCL rise, `{addr[6:0], rw}` is compared with `DEV_ADDR`. On a match go to ADDR_ACK; on a mismatch go to WAIT_STOP (no ACK).
  - **ADDR_ACK**: on the next SCL fall, drive `sda_oe`=1; hold it for one SCL period.
  - On the following SCL fall after ADDR_ACK:
    - `rw`=0: go to PTR_RX.
    - `rw`=1: load `mem[ptr]` into the shift register, drive its MSB (`sda_oe` = ~bit) and go to TX_BYTE.
  - **PTR_RX**: 8 bits; `ptr <= byte[PW-1:0]` (upper bits ignored). Then RX_ACK.
  - **DATA_RX**: 8 bits. On the 8th SCL rise: `mem[ptr] <= byte`, pulse `wr_valid` with the old `ptr`, then `ptr <= ptr+1`. Then RX_ACK.
  - **RX_ACK**: drive ACK low for one SCL period, then go to DATA_RX.
  - **TX_BYTE**: drives bits 6..0 on successive SCL falls. After the 8th bit's SCL fall, release SDA and go to TX_ACK.
  - **TX_ACK**: sample SDA on the SCL rise.
    - ACK (0): `ptr <= ptr+1`, load `mem[ptr+1]`, and drive its MSB on the next SCL fall.
    - NACK (1): `ptr <= ptr+1`, go to WAIT_STOP with SDA released.
  - **WAIT_STOP**: ignores the bus until START or STOP.
- **Pointer wrap.** `ptr` wraps from `MEM_DEPTH-1` to 0. It persists across transactions, so a read without a pointer phase continues from the last `ptr`.
- **Simultaneous edges.** If SCL and SDA change in the same synchronized sample, treat the event as an SCL edge only: no START or STOP.

## Timing
- Pad-to-decision latency is 3 `clk` cycles (2 synchronizer stages + 1 edge-detect stage). `sda_oe` updates in the cycle after an SCL fall is detected.
- `wr_valid` asserts the cycle after the 8th data bit's SCL rise is detected, with `wr_addr` and `wr_data` stable in that cycle.
- Memory reads are registered. The TX byte is loaded the cycle after the triggering event, before the next SCL fall.
- **Reset values:** `sda_oe`=0, `busy`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `ptr`=0, all memory bytes 0, state IDLE.
- **Reset asserted mid-transfer:** the target releases SDA on the next `clk` edge, discards the partial byte, and ignores the bus until a new START.

## Configuration
- Macro `I2C_TGT_GLITCH_FILTER_EN`.
- **Defined:** each synchronized line passes through a 3-sample stable filter; the output changes only after 3 consecutive equal samples. Decision latency becomes 6 cycles, and pulses of 2 cycles or less are rejected.
- **Undefined:** no filter; latency is 3 cycles.

## Structure
- Package `i2c_pkg`:
  - `i2c_tgt_state_t`
  - `I2C_ACK = 1'b0`
  - `I2C_NACK = 1'b1`
  - `I2C_SYNC_STAGES = 2`
- Sub-module `i2c_line_sync`, one instance per line. It contains the synchronizer, the optional filter, and the rise/fall pulse generation. Outputs: `lvl`, `rise`, `fall`.
- The top level holds the FSM, bit counter, shift register, `ptr` and memory.

## Test plan
- **Write burst.** START, 0xA0 (addr 0x50, W), ptr 0x10, data 0x11, 0x22, STOP -> ACK on all 4 bytes. `wr_valid` pulses twice: (0x10, 0x11) then (0x11, 0x22). `busy` drops after STOP.
- **Read with repeated START.** START, 0xA0, ptr 0x10, repeated START, 0xA1, read 2 bytes (controller ACK then NACK), STOP -> target returns 0x11 then 0x22, releases SDA after the NACK, and `ptr`=0x12.
- **Address mismatch.** START, 0xB0 -> `sda_oe` stays 0 for the whole frame; no `wr_valid`; the FSM ignores the bus until STOP.
- **Wrap-around.** Write ptr 0x7F with data 0xAA, 0xBB -> `mem[0x7F]`=0xAA and `mem[0x00]`=0xBB.
- **Abort.** Assert `rst` during bit 4 of a data byte -> `sda_oe`=0 on the next cycle; `mem` is unchanged (all zeros); the next full write transaction succeeds.
- **Glitch filter.** With `I2C_TGT_GLITCH_FILTER_EN` defined, inject a 2-cycle SCL low pulse mid-byte -> no bit shifted and no state change. Without the macro, the same pulse is counted as a clock edge.
